// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
//
// Walks a SPRITE_W x SPRITE_H sprite stored in an external ROM in raster order
// and emits one pixel write per cycle, optionally mirrored horizontally. The
// ROM has a fixed one-cycle read latency, so each pixel's screen coordinates are
// registered one cycle after its address is presented. The registered
// coordinates therefore line up with the returning rom_q.
//
// Optional feature: define SPRITE_TRANSPARENCY_EN to suppress plot for pixels
// whose colour equals TRANSPARENT_KEY. Timing, counters and done are unchanged.
//
// Ports
//   clock_all    in   1         sole clock, rising edge
//   reset_all    in   1         synchronous, active-high reset
//   start        in   1         request to draw one sprite (accepted in IDLE)
//   mirror       in   1         1 = draw horizontally flipped
//   x_           in   9         screen X of sprite top-left corner
//   y_           in   8         screen Y of sprite top-left corner
//   rom_address  out  ADDR_W    sprite ROM address (0 outside FETCH)
//   rom_q        in   COLOUR_W  ROM data for the previous cycle's address
//   out_x        out  9         pixel X (wraps mod 512)
//   out_y        out  8         pixel Y (wraps mod 256)
//   out_colour   out  COLOUR_W  pixel colour (rom_q, combinational)
//   plot         out  1         write out_x/out_y/out_colour this cycle
//   busy         out  1         high in FETCH and FLUSH
//   done         out  1         one-cycle pulse when the sprite is complete
// -----------------------------------------------------------------------------
module sprite_blitter #(
  parameter int                  SPRITE_W        = 70,
  parameter int                  SPRITE_H        = 71,
  parameter int                  ADDR_W          = 13,
  parameter int                  COLOUR_W        = 3,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = '0
) (
  input  logic                clock_all,
  input  logic                reset_all,
  input  logic                start,
  input  logic                mirror,
  input  logic [8:0]          x_,
  input  logic [7:0]          y_,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [8:0]          out_x,
  output logic [7:0]          out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    FINISH
  } state_t;

  // Counters are 8 bits wide because both dimensions are capped at 256.
  localparam logic [7:0]        LAST_CX  = 8'(SPRITE_W - 1);
  localparam logic [7:0]        LAST_CY  = 8'(SPRITE_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPRITE_W);

  state_t              state;
  state_t              next_state;
  logic [7:0]          cx;
  logic [7:0]          cy;
  logic [ADDR_W-1:0]   row_base;     // cy * SPRITE_W, kept incrementally
  logic [8:0]          x_lat;
  logic [7:0]          y_lat;
  logic                mirror_lat;
  logic                pixel_valid;  // previous cycle was a FETCH cycle
  logic                last_pixel;
  logic [7:0]          col;

  assign last_pixel = (cx == LAST_CX) && (cy == LAST_CY);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_all) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked branch
    // and does not appear in the sensitivity list.
    if (reset_all) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default is assigned first so every path drives next_state and
    // no latch is inferred.
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   if (last_pixel) next_state = FLUSH;
      FLUSH:   next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, latched request and registered pixel coordinates
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      cx          <= '0;
      cy          <= '0;
      row_base    <= '0;
      x_lat       <= '0;
      y_lat       <= '0;
      mirror_lat  <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      pixel_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // values from before this edge, whatever the statement order.
      pixel_valid <= (state == FETCH);
      case (state)
        IDLE: begin
          if (start) begin
            cx         <= '0;
            cy         <= '0;
            row_base   <= '0;
            x_lat      <= x_;
            y_lat      <= y_;
            mirror_lat <= mirror;
          end
        end
        FETCH: begin
          // Coordinates trail the address by one cycle to meet rom_q.
          // Screen X always advances left to right; mirroring only
          // changes which ROM column is read.
          out_x <= x_lat + {1'b0, cx};
          out_y <= y_lat + cy;
          if (cx == LAST_CX) begin
            cx <= '0;
            if (cy == LAST_CY) begin
              cy       <= '0;
              row_base <= '0;
            end else begin
              cy       <= cy + 8'd1;
              row_base <= row_base + ROW_STEP;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // ROM address: raster order, or reversed within each row when mirrored
  // ---------------------------------------------------------------------------
  always_comb begin
    col         = mirror_lat ? (LAST_CX - cx) : cx;
    rom_address = '0;
    if (state == FETCH) begin
      rom_address = row_base + ADDR_W'(col);
    end
  end

  assign out_colour = rom_q;
  assign busy       = (state == FETCH) || (state == FLUSH);
  assign done       = (state == FINISH);

`ifdef SPRITE_TRANSPARENCY_EN
  assign plot = pixel_valid && (rom_q != TRANSPARENT_KEY);
`else
  assign plot = pixel_valid;

  // The key only matters when transparency is compiled in. This tie-off
  // keeps it referenced without affecting any output.
  logic unused_key;
  assign unused_key = ^TRANSPARENT_KEY;
`endif

endmodule

// File: tb/tb_sprite_blitter.sv
`timescale 1ns/1ps
module tb_sprite_blitter;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic clock_all = 1'b0;
  always #5 clock_all = ~clock_all;

  logic       reset_all;
  logic       mirror;
  logic [8:0] x_;
  logic [7:0] y_;
  logic       start_def, start_mir, start_wrap;

  // Instance "def": default parameters (70 x 71)
  logic [12:0] rom_address_def;
  logic [2:0]  rom_q_def, out_colour_def;
  logic [8:0]  out_x_def;
  logic [7:0]  out_y_def;
  logic        plot_def, busy_def, done_def;

  // Instance "mir": 4 x 2
  logic [2:0]  rom_address_mir;
  logic [2:0]  rom_q_mir, out_colour_mir;
  logic [8:0]  out_x_mir;
  logic [7:0]  out_y_mir;
  logic        plot_mir, busy_mir, done_mir;

  // Instance "wrap": 16 x 2
  logic [4:0]  rom_address_wrap;
  logic [2:0]  rom_q_wrap, out_colour_wrap;
  logic [8:0]  out_x_wrap;
  logic [7:0]  out_y_wrap;
  logic        plot_wrap, busy_wrap, done_wrap;

  sprite_blitter u_def (
    .clock_all(clock_all), .reset_all(reset_all), .start(start_def),
    .mirror(mirror), .x_(x_), .y_(y_),
    .rom_address(rom_address_def), .rom_q(rom_q_def),
    .out_x(out_x_def), .out_y(out_y_def), .out_colour(out_colour_def),
    .plot(plot_def), .busy(busy_def), .done(done_def)
  );

  sprite_blitter #(.SPRITE_W(4), .SPRITE_H(2), .ADDR_W(3)) u_mir (
    .clock_all(clock_all), .reset_all(reset_all), .start(start_mir),
    .mirror(mirror), .x_(x_), .y_(y_),
    .rom_address(rom_address_mir), .rom_q(rom_q_mir),
    .out_x(out_x_mir), .out_y(out_y_mir), .out_colour(out_colour_mir),
    .plot(plot_mir), .busy(busy_mir), .done(done_mir)
  );

  sprite_blitter #(.SPRITE_W(16), .SPRITE_H(2), .ADDR_W(5)) u_wrap (
    .clock_all(clock_all), .reset_all(reset_all), .start(start_wrap),
    .mirror(mirror), .x_(x_), .y_(y_),
    .rom_address(rom_address_wrap), .rom_q(rom_q_wrap),
    .out_x(out_x_wrap), .out_y(out_y_wrap), .out_colour(out_colour_wrap),
    .plot(plot_wrap), .busy(busy_wrap), .done(done_wrap)
  );

  // ROM models: contents = address mod 8, one-cycle read latency.
  always @(posedge clock_all) begin
    rom_q_def  <= rom_address_def[2:0];
    rom_q_mir  <= rom_address_mir[2:0];
    rom_q_wrap <= rom_address_wrap[2:0];
  end

  int   n_checks = 0;
  int   n_errors = 0;
  pix_t q_def[$];
  pix_t q_mir[$];
  pix_t q_wrap[$];

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic busy_of(input int idx);
    case (idx)
      0:       return busy_def;
      1:       return busy_mir;
      default: return busy_wrap;
    endcase
  endfunction

  function automatic logic done_of(input int idx);
    case (idx)
      0:       return done_def;
      1:       return done_mir;
      default: return done_wrap;
    endcase
  endfunction

  function automatic int q_size(input int idx);
    case (idx)
      0:       return q_def.size();
      1:       return q_mir.size();
      default: return q_wrap.size();
    endcase
  endfunction

  // Expected pixels of one sprite in plot order.
  task automatic push_sprite(input int idx, input int w, input int h,
                             input int x, input int y, input bit mir);
    pix_t p;
    int   addr;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        addr = cy * w + (mir ? (w - 1 - cx) : cx);
        p.x  = 9'(x + cx);
        p.y  = 8'(y + cy);
        p.c  = 3'(addr % 8);
`ifdef SPRITE_TRANSPARENCY_EN
        if (p.c == 3'd0) continue;
`endif
        case (idx)
          0:       q_def.push_back(p);
          1:       q_mir.push_back(p);
          default: q_wrap.push_back(p);
        endcase
      end
    end
  endtask

  task automatic sb_check(input int idx, input string tag, input pix_t got);
    pix_t exp_p;
    if (q_size(idx) == 0) begin
      check({tag, " queue depth at plot"}, 0, 1);
    end else begin
      case (idx)
        0:       exp_p = q_def.pop_front();
        1:       exp_p = q_mir.pop_front();
        default: exp_p = q_wrap.pop_front();
      endcase
      check({tag, " pixel {x,y,colour}"}, 32'(got), 32'(exp_p));
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clock_all) begin
    if (plot_def === 1'b1)  sb_check(0, "def",  {out_x_def,  out_y_def,  out_colour_def});
    if (plot_mir === 1'b1)  sb_check(1, "mir",  {out_x_mir,  out_y_mir,  out_colour_mir});
    if (plot_wrap === 1'b1) sb_check(2, "wrap", {out_x_wrap, out_y_wrap, out_colour_wrap});
  end

  // Called in cycle 1 of a draw (one cycle after start acceptance). Checks
  // the busy profile and that done pulses in cycle n+2, with a bounded wait.
  task automatic time_draw(input int idx, input int n, input string tag);
    int c        = 1;
    int got      = -1;
    bit busy_bad = 1'b0;
    while (c <= n + 8) begin
      if (busy_of(idx) !== (c <= n + 1)) busy_bad = 1'b1;
      if (done_of(idx) === 1'b1) begin
        got = c;
        break;
      end
      @(posedge clock_all);
      #1;
      c++;
    end
    check({tag, " done cycle"}, got, n + 2);
    check({tag, " busy profile"}, 32'(busy_bad), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet_bad;

    reset_all  = 1'b1;
    start_def  = 1'b0;
    start_mir  = 1'b0;
    start_wrap = 1'b0;
    mirror     = 1'b0;
    x_         = '0;
    y_         = '0;
    repeat (3) @(posedge clock_all);
    #1;

    // Reset state
    check("reset plot",        32'(plot_def), 0);
    check("reset busy",        32'(busy_def), 0);
    check("reset done",        32'(done_def), 0);
    check("reset rom_address", 32'(rom_address_def), 0);
    check("reset out_x",       32'(out_x_def), 0);
    check("reset out_y",       32'(out_y_def), 0);
    check("reset mir busy",    32'(busy_mir), 0);
    check("reset wrap plot",   32'(plot_wrap), 0);

    reset_all = 1'b0;
    @(posedge clock_all);
    #1;

    // Default sprite at (10,20), raster order; inputs change after acceptance
    x_ = 9'd10; y_ = 8'd20; mirror = 1'b0;
    push_sprite(0, 70, 71, 10, 20, 1'b0);
    start_def = 1'b1;
    @(posedge clock_all);
    #1;
    start_def = 1'b0;
    x_ = 9'd300; y_ = 8'd200; mirror = 1'b1;
    time_draw(0, 4970, "def");
    @(posedge clock_all);
    #1;
    check("def leftover pixels", q_size(0), 0);
    check("def idle busy", 32'(busy_def), 0);

    // Mirrored 4x2: addresses 3,2,1,0,7,6,5,4
    x_ = 9'd100; y_ = 8'd50; mirror = 1'b1;
    push_sprite(1, 4, 2, 100, 50, 1'b1);
    start_mir = 1'b1;
    @(posedge clock_all);
    #1;
    start_mir = 1'b0;
    time_draw(1, 8, "mir");
    @(posedge clock_all);
    #1;
    check("mir leftover pixels", q_size(1), 0);

    // 16x2 at (500,255): X wraps 511 -> 0, Y wraps 255 -> 0
    x_ = 9'd500; y_ = 8'd255; mirror = 1'b0;
    push_sprite(2, 16, 2, 500, 255, 1'b0);
    start_wrap = 1'b1;
    @(posedge clock_all);
    #1;
    start_wrap = 1'b0;
    time_draw(2, 32, "wrap");
    @(posedge clock_all);
    #1;
    check("wrap leftover pixels", q_size(2), 0);

    // start held high: one draw per IDLE entry; inputs changed mid-draw only
    // affect the next draw
    x_ = 9'd20; y_ = 8'd10; mirror = 1'b0;
    push_sprite(1, 4, 2, 20, 10, 1'b0);
    push_sprite(1, 4, 2, 40, 10, 1'b1);
    start_mir = 1'b1;
    @(posedge clock_all);
    #1;
    x_ = 9'd40; mirror = 1'b1;
    time_draw(1, 8, "held first");
    @(posedge clock_all);
    #1;
    check("held idle gap busy", 32'(busy_mir), 0);
    @(posedge clock_all);
    #1;
    start_mir = 1'b0;
    check("held second accepted", 32'(busy_mir), 1);
    time_draw(1, 8, "held second");
    repeat (3) @(posedge clock_all);
    #1;
    check("held no third draw", 32'(busy_mir), 0);
    check("held leftover pixels", q_size(1), 0);

    // Reset aborts a draw at pixel 100; start is ignored while in reset
    x_ = 9'd5; y_ = 8'd5; mirror = 1'b0;
    push_sprite(0, 70, 71, 5, 5, 1'b0);
    start_def = 1'b1;
    @(posedge clock_all);
    #1;
    start_def = 1'b0;
    repeat (101) @(posedge clock_all);
    #1;
    check("abort busy before reset", 32'(busy_def), 1);
    reset_all = 1'b1;
    start_def = 1'b1;
    @(posedge clock_all);
    #1;
    reset_all = 1'b0;
    start_def = 1'b0;
    check("abort plot",        32'(plot_def), 0);
    check("abort busy",        32'(busy_def), 0);
    check("abort done",        32'(done_def), 0);
    check("abort rom_address", 32'(rom_address_def), 0);
    q_def.delete();
    quiet_bad = 1'b0;
    repeat (20) begin
      @(posedge clock_all);
      #1;
      if (plot_def !== 1'b0 || done_def !== 1'b0 || busy_def !== 1'b0) quiet_bad = 1'b1;
    end
    check("abort stays quiet", 32'(quiet_bad), 0);

    check("final def queue",  q_size(0), 0);
    check("final mir queue",  q_size(1), 0);
    check("final wrap queue", q_size(2), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
